fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 128 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan controller: converts a 14-bit binary value to BCD with a
// sequential double-dabble, then time-multiplexes the digits with leading-zero blanking.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_ovf,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        r_state;
  logic [13:0]   r_shift;
  logic [15:0]   r_bcd;
  logic [15:0]   r_disp;
  logic [3:0]    r_bitCnt;
  logic          r_busy;
  logic          r_ovf;
  logic [CW-1:0] r_scanCnt;
  logic [1:0]    r_digitSel;

  logic [15:0]   w_bcdAdj;
  logic [15:0]   w_bcdNext;
  logic          w_unusedTopBit;

  always_comb begin
    w_bcdAdj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_bcdAdj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  // The adjusted top bit is shifted out; it is always 0 for inputs clamped to 9999.
  assign w_bcdNext      = {w_bcdAdj[14:0], r_shift[13]};
  assign w_unusedTopBit = w_bcdAdj[15];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_disp   <= '0;
      r_bitCnt <= '0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_shift  <= (i_value > 14'd9999) ? 14'd9999 : i_value;
            r_ovf    <= (i_value > 14'd9999);
            r_bcd    <= '0;
            r_bitCnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= CONV;
          end
        end
        CONV: begin
          r_bcd    <= w_bcdNext;
          r_shift  <= {r_shift[12:0], 1'b0};
          r_bitCnt <= r_bitCnt + 4'd1;
          if (r_bitCnt == 4'd13) begin
            r_disp  <= w_bcdNext;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scanCnt  <= '0;
      r_digitSel <= 2'd0;
    end else if (r_scanCnt == SCAN_LAST) begin
      r_scanCnt  <= '0;
      r_digitSel <= r_digitSel + 2'd1;
    end else begin
      r_scanCnt  <= r_scanCnt + CW'(1);
    end
  end

  // Blank a digit only when it and every more significant digit are zero.
  always_comb begin
    o_value = r_disp[3:0];
    o_en    = 1'b1;
    case (r_digitSel)
      2'd0: begin
        o_value = r_disp[3:0];
        o_en    = 1'b1;
      end
      2'd1: begin
        o_value = r_disp[7:4];
        o_en    = |r_disp[15:4];
      end
      2'd2: begin
        o_value = r_disp[11:8];
        o_en    = |r_disp[15:8];
      end
      default: begin
        o_value = r_disp[15:12];
        o_en    = |r_disp[15:12];
      end
    endcase
  end

  assign o_busy        = r_busy;
  assign o_ovf         = r_ovf;
  assign o_digitSelect = r_digitSel;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller at SCAN_DIV=4: expected displays are
// queued when a load is driven and popped once the conversion finishes.
module tb_fnd_scan_controller;

  typedef struct {
    int value;
    bit ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic        ovf;
  logic [1:0]  digitSelect;
  logic [3:0]  digitValue;
  logic        en;

  exp_t        sb[$];
  logic [15:0] curDisp;
  int          nChecks;
  int          nPass;

  fnd_scan_controller #(.SCAN_DIV(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_value       (value),
    .i_load        (load),
    .o_busy        (busy),
    .o_ovf         (ovf),
    .o_digitSelect (digitSelect),
    .o_value       (digitValue),
    .o_en          (en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] expDisp(input int v);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'((v / 1000) % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [3:0] expEn(input int v);
    return {v >= 1000, v >= 100, v >= 10, 1'b1};
  endfunction

  // Drives one load pulse into the capture edge and queues the expected display.
  task automatic applyStimulus(input int v);
    exp_t e;
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    e.value = (v > 9999) ? 9999 : v;
    e.ovf   = (v > 9999);
    sb.push_back(e);
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic waitBusy(input logic [15:0] prevDisp, output int busyN, output int badN);
    busyN = 0;
    badN  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      busyN++;
      if (digitValue !== prevDisp[4*digitSelect +: 4]) badN++;
    end
  endtask

  // Aligns on a digit change, then records one full scan of four 4-cycle slots.
  task automatic scanCapture(output logic [15:0] d, output logic [3:0] e, output bit ok);
    logic [1:0] prevSel;
    logic [1:0] startSel;
    logic [1:0] k;
    int         guard;
    ok = 1'b1;
    d  = '0;
    e  = '0;
    @(negedge clk);
    prevSel = digitSelect;
    guard   = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (digitSelect == prevSel && guard < 8);
    if (digitSelect == prevSel) ok = 1'b0;
    startSel = digitSelect;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      k = startSel + 2'(i / 4);
      if (digitSelect !== k) ok = 1'b0;
      if (i % 4 == 0) begin
        d[4*k +: 4] = digitValue;
        e[k]        = en;
      end else if (digitValue !== d[4*k +: 4] || en !== e[k]) begin
        ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    load  = 1'b0;
    value = '0;
    #1 rst_n = 1'b0;
    #2;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else nPass++;
    nChecks++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); else nPass++;
    nChecks++; if (digitSelect !== 2'd0) $display("[TB] FAIL reset_sel got=%0d exp=0", digitSelect); else nPass++;
    nChecks++; if (digitValue !== 4'd0) $display("[TB] FAIL reset_value got=%0d exp=0", digitValue); else nPass++;
    nChecks++; if (en !== 1'b1) $display("[TB] FAIL reset_en got=%b exp=1", en); else nPass++;
    @(negedge clk);
    rst_n = 1'b1;
    curDisp = '0;
  endtask

  task automatic test_load_display(input int v);
    exp_t        e;
    int          busyN, badN;
    logic [15:0] d;
    logic [3:0]  dEn;
    bit          ok;
    applyStimulus(v);
    waitBusy(curDisp, busyN, badN);
    nChecks++; if (busyN !== 14) $display("[TB] FAIL load%0d_busy_cycles got=%0d exp=14", v, busyN); else nPass++;
    nChecks++; if (badN !== 0) $display("[TB] FAIL load%0d_partial_shown got=%0d exp=0", v, badN); else nPass++;
    e.value = -1;
    e.ovf   = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    scanCapture(d, dEn, ok);
    nChecks++; if (d !== expDisp(e.value)) $display("[TB] FAIL load%0d_digits got=%h exp=%h", v, d, expDisp(e.value)); else nPass++;
    nChecks++; if (dEn !== expEn(e.value)) $display("[TB] FAIL load%0d_en got=%b exp=%b", v, dEn, expEn(e.value)); else nPass++;
    nChecks++; if (ok !== 1'b1) $display("[TB] FAIL load%0d_scan_order got=%b exp=1", v, ok); else nPass++;
    nChecks++; if (ovf !== e.ovf) $display("[TB] FAIL load%0d_ovf got=%b exp=%b", v, ovf, e.ovf); else nPass++;
    curDisp = expDisp(e.value);
  endtask

  task automatic test_overflow();
    exp_t        e;
    int          busyN, badN;
    logic [15:0] d;
    logic [3:0]  dEn;
    bit          ok;
    applyStimulus(12000);
    nChecks++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_set got=%b exp=1", ovf); else nPass++;
    waitBusy(curDisp, busyN, badN);
    nChecks++; if (busyN !== 14) $display("[TB] FAIL ovf_busy_cycles got=%0d exp=14", busyN); else nPass++;
    e.value = -1;
    if (sb.size() > 0) e = sb.pop_front();
    scanCapture(d, dEn, ok);
    nChecks++; if (d !== expDisp(e.value)) $display("[TB] FAIL ovf_clamped got=%h exp=%h", d, expDisp(e.value)); else nPass++;
    nChecks++; if (dEn !== expEn(e.value)) $display("[TB] FAIL ovf_en got=%b exp=%b", dEn, expEn(e.value)); else nPass++;
    curDisp = expDisp(e.value);
    applyStimulus(5);
    nChecks++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_clear got=%b exp=0", ovf); else nPass++;
    waitBusy(curDisp, busyN, badN);
    e.value = -1;
    if (sb.size() > 0) e = sb.pop_front();
    scanCapture(d, dEn, ok);
    nChecks++; if (d !== expDisp(e.value)) $display("[TB] FAIL ovf_next_digits got=%h exp=%h", d, expDisp(e.value)); else nPass++;
    nChecks++; if (dEn !== expEn(e.value)) $display("[TB] FAIL ovf_next_en got=%b exp=%b", dEn, expEn(e.value)); else nPass++;
    curDisp = expDisp(e.value);
  endtask

  task automatic test_ignore_in_conv();
    exp_t        e;
    int          busyN, restN, badN;
    logic [15:0] d;
    logic [3:0]  dEn;
    bit          ok;
    applyStimulus(1234);
    busyN = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busyN++;
    end
    value = 14'd5678;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    waitBusy(curDisp, restN, badN);
    nChecks++; if (busyN + restN !== 14) $display("[TB] FAIL ignore_busy_cycles got=%0d exp=14", busyN + restN); else nPass++;
    nChecks++; if (ovf !== 1'b0) $display("[TB] FAIL ignore_ovf got=%b exp=0", ovf); else nPass++;
    e.value = -1;
    if (sb.size() > 0) e = sb.pop_front();
    scanCapture(d, dEn, ok);
    nChecks++; if (d !== expDisp(e.value)) $display("[TB] FAIL ignore_digits got=%h exp=%h", d, expDisp(e.value)); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL ignore_no_restart got=%b exp=0", busy); else nPass++;
    curDisp = expDisp(e.value);
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    int          busyN, badN;
    logic [15:0] d;
    logic [3:0]  dEn;
    bit          ok;
    test_load_display(1234);
    applyStimulus(900);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got=%b exp=0", busy); else nPass++;
    nChecks++; if (digitSelect !== 2'd0) $display("[TB] FAIL midrst_sel got=%0d exp=0", digitSelect); else nPass++;
    nChecks++; if (digitValue !== 4'd0) $display("[TB] FAIL midrst_value got=%0d exp=0", digitValue); else nPass++;
    nChecks++; if (en !== 1'b1) $display("[TB] FAIL midrst_en got=%b exp=1", en); else nPass++;
    sb.delete();
    curDisp = '0;
    @(negedge clk);
    rst_n   = 1'b1;
    value   = 14'd1050;
    load    = 1'b1;
    e.value = 1050;
    e.ovf   = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1 load = 1'b0;
    nChecks++; if (busy !== 1'b1) $display("[TB] FAIL first_load_busy got=%b exp=1", busy); else nPass++;
    waitBusy(curDisp, busyN, badN);
    nChecks++; if (busyN !== 14) $display("[TB] FAIL first_load_busy_cycles got=%0d exp=14", busyN); else nPass++;
    nChecks++; if (badN !== 0) $display("[TB] FAIL midrst_display_zero got=%0d exp=0", badN); else nPass++;
    e.value = -1;
    if (sb.size() > 0) e = sb.pop_front();
    scanCapture(d, dEn, ok);
    nChecks++; if (d !== expDisp(e.value)) $display("[TB] FAIL embedded_zero_digits got=%h exp=%h", d, expDisp(e.value)); else nPass++;
    nChecks++; if (dEn !== expEn(e.value)) $display("[TB] FAIL embedded_zero_en got=%b exp=%b", dEn, expEn(e.value)); else nPass++;
    nChecks++; if (ok !== 1'b1) $display("[TB] FAIL embedded_zero_scan got=%b exp=1", ok); else nPass++;
    curDisp = expDisp(e.value);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    curDisp = '0;
    test_reset();
    test_load_display(1234);
    test_load_display(7);
    test_load_display(0);
    test_overflow();
    test_ignore_in_conv();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
